pin_id_formatter: RTL and testbench

//  Upstream feeder of the 8N1 UART transmitter in the pin-scan design.

---
 rtl/pin_scan_pkg.sv | 30 +++
 rtl/dec_split_seq.sv | 75 +++++++
 rtl/pin_id_formatter.sv | 113 +++++++++++
 tb/tb_pin_id_formatter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pin_scan_pkg.sv
// Shared constants and state encodings for the pin-scan report formatters.
// Also provides the digit-to-ASCII helper used by the byte mux.
package pin_scan_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_P  = 8'h50;

  // Message is PREFIX, three digits, CR, LF.
  localparam logic [2:0] MSG_LAST = 3'd5;

  typedef enum logic [1:0] {
    FMT_IDLE,
    FMT_CONV,
    FMT_SEND,
    FMT_DONE
  } fmt_state_e;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_CONV_H,
    DEC_CONV_T
  } dec_state_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/dec_split_seq.sv
// Sequential 8-bit binary to hundreds/tens/units splitter.
// Takes one subtraction per cycle; done is high during the final cycle, and u is valid after that edge.
module dec_split_seq
  import pin_scan_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       go,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] h,
  output logic [3:0] t,
  output logic [3:0] u
);

  dec_state_e state_q, state_d;
  logic [7:0] rem_q;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      DEC_IDLE:   if (go) state_d = DEC_CONV_H;
      DEC_CONV_H: if (rem_q < 8'd100) state_d = DEC_CONV_T;
      DEC_CONV_T: begin
        if (rem_q < 8'd10) begin
          state_d = DEC_IDLE;
          done    = 1'b1;
        end
      end
      default:    state_d = DEC_IDLE;
    endcase
  end

  assign busy = (state_q != DEC_IDLE);

  // h/t/u hold their values after completion so the sender can read them freely.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= DEC_IDLE;
      rem_q   <= 8'd0;
      h       <= 4'd0;
      t       <= 4'd0;
      u       <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DEC_IDLE: begin
          if (go) begin
            rem_q <= bin;
            h     <= 4'd0;
            t     <= 4'd0;
          end
        end
        DEC_CONV_H: begin
          if (rem_q >= 8'd100) begin
            rem_q <= rem_q - 8'd100;
            h     <= h + 4'd1;
          end
        end
        DEC_CONV_T: begin
          if (rem_q >= 8'd10) begin
            rem_q <= rem_q - 8'd10;
            t     <= t + 4'd1;
          end else begin
            u <= rem_q[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pin_id_formatter.sv
// Formats a pin index as "P<ddd>\r\n" and streams it one byte at a time over valid/ready.
// The splitter does the decimal conversion; this level sequences the message and handshake.
module pin_id_formatter
  import pin_scan_pkg::*;
#(
  parameter int         IDX_W  = 8,
  parameter logic [7:0] PREFIX = ASCII_P
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       tx_byte_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i
);

  fmt_state_e state_q, state_d;
  logic [2:0] k_q, k_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  logic       dec_go, dec_busy, dec_done;
  logic [3:0] dig_h, dig_t, dig_u;

  assign dec_go = (state_q == FMT_IDLE) && start_i && !dec_busy;

  dec_split_seq u_dec (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .go      (dec_go),
    .bin     (idx_i),
    .busy    (dec_busy),
    .done    (dec_done),
    .h       (dig_h),
    .t       (dig_t),
    .u       (dig_u)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      FMT_IDLE: begin
        if (dec_go) begin
          state_d = FMT_CONV;
          busy_d  = 1'b1;
        end
      end
      FMT_CONV: begin
        if (dec_done) begin
          state_d = FMT_SEND;
          k_d     = 3'd0;
          valid_d = 1'b1;
        end
      end
      FMT_SEND: begin
        // Advance on each transfer so the next byte appears without a bubble.
        if (valid_q && tx_ready_i) begin
          if (k_q == MSG_LAST) begin
            state_d = FMT_DONE;
            valid_d = 1'b0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      FMT_DONE: begin
        state_d = FMT_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = FMT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= FMT_IDLE;
      k_q     <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    tx_byte_o = 8'h00;
    if (state_q == FMT_SEND) begin
      case (k_q)
        3'd0:    tx_byte_o = PREFIX;
        3'd1:    tx_byte_o = ascii_digit(dig_h);
        3'd2:    tx_byte_o = ascii_digit(dig_t);
        3'd3:    tx_byte_o = ascii_digit(dig_u);
        3'd4:    tx_byte_o = ASCII_CR;
        3'd5:    tx_byte_o = ASCII_LF;
        default: tx_byte_o = 8'h00;
      endcase
    end
  end

  assign tx_valid_o = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = (state_q == FMT_DONE);

endmodule

// File: tb/tb_pin_id_formatter.sv
// Directed bench for pin_id_formatter: table of messages plus a mid-message reset sequence.
module tb_pin_id_formatter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] idx;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] tx_byte;
  logic       tx_valid;

  always #5 clk = ~clk;

  pin_id_formatter dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .idx_i      (idx),
    .busy_o     (busy),
    .done_o     (done),
    .tx_byte_o  (tx_byte),
    .tx_valid_o (tx_valid),
    .tx_ready_i (ready)
  );

  // mode 0: ready always high; mode 1: ready one cycle in three.
  // hold: start stays high and idx is scrambled while the message runs.
  typedef struct {
    logic [7:0]  idx;
    int          mode;
    bit          hold;
    int          lat;
    logic [47:0] bytes;
  } vec_t;

  vec_t tbl[7];
  int   num_vec  = 0;
  int   num_miss = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    num_vec++;
    if (act != exp) begin
      num_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one full message starting at a negedge and returns at the negedge of the IDLE cycle.
  task automatic applyStimulus(input vec_t v);
    int         lat;
    int         ntx;
    int         cyc;
    int         phase;
    bit         stalled;
    bit         rdy;
    logic [7:0] held;
    logic [7:0] got[6];
    for (int j = 0; j < 6; j++) got[j] = 8'h00;
    ready = (v.mode == 0);
    start = 1'b1;
    idx   = v.idx;
    @(posedge clk); @(negedge clk);
    checkOutput("accept_busy", int'(busy), 1);
    if (v.hold) idx = 8'($urandom);
    else        start = 1'b0;

    lat = 0;
    while (!tx_valid && lat < 40) begin
      if (v.hold) begin
        idx = 8'($urandom);
        checkOutput("busy_conv", int'(busy), 1);
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("first_valid_lat idx=%0d", v.idx), lat, v.lat);

    ntx = 0; cyc = 0; phase = 1; stalled = 1'b0; held = 8'h00;
    while (ntx < 6 && cyc < 100) begin
      checkOutput("valid_held", int'(tx_valid), 1);
      if (stalled) checkOutput("stall_byte", int'(tx_byte), int'(held));
      rdy = (v.mode == 0) || (phase % 3 == 0);
      phase++;
      ready = rdy;
      if (rdy) begin
        got[ntx] = tx_byte;
        ntx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = tx_byte;
      end
      if (v.hold) begin
        idx = 8'($urandom);
        checkOutput("busy_send", int'(busy), 1);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    checkOutput("transfers", ntx, 6);
    for (int j = 0; j < 6; j++)
      checkOutput($sformatf("byte%0d idx=%0d", j, v.idx), int'(got[j]), int'(v.bytes[47-8*j -: 8]));

    checkOutput("done_pulse", int'(done), 1);
    checkOutput("valid_after_lf", int'(tx_valid), 0);
    checkOutput("busy_in_done", int'(busy), 1);
    if (v.hold) idx = 8'($urandom);
    @(posedge clk); @(negedge clk);
    checkOutput("done_clear", int'(done), 0);
    checkOutput("busy_clear", int'(busy), 0);
    checkOutput("valid_idle", int'(tx_valid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    tbl[0] = '{idx: 8'd0,   mode: 0, hold: 1'b0, lat: 2,  bytes: 48'h50_30_30_30_0D_0A};
    tbl[1] = '{idx: 8'd255, mode: 0, hold: 1'b0, lat: 9,  bytes: 48'h50_32_35_35_0D_0A};
    tbl[2] = '{idx: 8'd107, mode: 1, hold: 1'b0, lat: 3,  bytes: 48'h50_31_30_37_0D_0A};
    tbl[3] = '{idx: 8'd58,  mode: 0, hold: 1'b1, lat: 7,  bytes: 48'h50_30_35_38_0D_0A};
    tbl[4] = '{idx: 8'd199, mode: 0, hold: 1'b1, lat: 12, bytes: 48'h50_31_39_39_0D_0A};
    tbl[5] = '{idx: 8'd100, mode: 1, hold: 1'b0, lat: 3,  bytes: 48'h50_31_30_30_0D_0A};
    tbl[6] = '{idx: 8'd9,   mode: 0, hold: 1'b0, lat: 2,  bytes: 48'h50_30_30_39_0D_0A};

    rst_n = 1'b0; start = 1'b0; idx = 8'h00; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy",  int'(busy), 0);
    checkOutput("rst_done",  int'(done), 0);
    checkOutput("rst_valid", int'(tx_valid), 0);
    checkOutput("rst_byte",  int'(tx_byte), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(tbl[i]);

    // Abort idx=42 after its third byte has been transferred.
    ready = 1'b1; start = 1'b1; idx = 8'd42;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!tx_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    checkOutput("abort_first_valid_lat", lat, 6);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
    end
    checkOutput("abort_byte3_offered", int'(tx_byte), 8'h32);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("abort_valid", int'(tx_valid), 0);
    checkOutput("abort_busy",  int'(busy), 0);
    checkOutput("abort_done",  int'(done), 0);
    checkOutput("abort_byte",  int'(tx_byte), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      checkOutput("post_abort_quiet", int'(done | tx_valid | busy), 0);
    end

    applyStimulus(tbl[6]);

    $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_miss);
    $finish;
  end

endmodule
